clk_edge_generator: RTL and testbench

- Downstream stage of the rate tracker. Owns the free-running rate counter and compares it against the tracker's half-rate target.
- Toggles the generated clock on a match and emits the unpausable clock state with edge events; the tracker consumes both to compute the next target.
- Also produces a pausable copy of the clock with a glitch-free pause/resume handshake.

---
 rtl/clk_edge_generator_pkg.sv | 30 +++
 rtl/clk_edge_generator_pause_gate.sv | 38 +++
 rtl/clk_edge_generator.sv | 83 ++++++++
 tb/tb_clk_edge_generator.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/clk_edge_generator_pkg.sv
// clk_edge_generator_pkg: shared clock-domain bundle and clock-state types for the rate tracker slice.
//   common_p::clk_dom_s      : clk, sync_rst (active-high, synchronous), clk_en (cycle enable)
//   clks_alot_p::clock_state_s      : generated clock level plus its edge events
//   clks_alot_p::recovered_events_s : edge events recovered from an external clock
package common_p;
   typedef struct packed {
      logic clk;
      logic sync_rst;
      logic clk_en;
   } clk_dom_s;
endpackage

package clks_alot_p;
   localparam int RATE_COUNTER_WIDTH = 16;
   typedef struct packed {
      logic rising_edge;
      logic falling_edge;
      logic any_valid_edge;
   } edge_events_s;
   typedef struct packed {
      logic         clk;
      edge_events_s events;
   } clock_state_s;
   typedef struct packed {
      logic rising_edge;
      logic falling_edge;
      logic any_valid_edge;
   } recovered_events_s;
   typedef enum logic {GEN_IDLE, GEN_RUN} gen_state_e;
endpackage

// File: rtl/clk_edge_generator_pause_gate.sv
// clk_pause_gate: glitch-free pausable copy of the generated clock state.
//   sys_dom_i            : clock / sync reset / cycle enable bundle
//   clear_state_i        : soft clear, unpauses and drops the ack
//   pause_req_i          : level pause request
//   unpausable_d_i       : next-cycle unpausable clock state from the edge generator
//   pause_ack_o          : pausable clock is parked low
//   pausable_clk_state_o : registered gated clock state
module clk_pause_gate
   import clks_alot_p::*;
(
   input  common_p::clk_dom_s sys_dom_i,
   input  logic               clear_state_i,
   input  logic               pause_req_i,
   input  clock_state_s       unpausable_d_i,
   output logic               pause_ack_o,
   output clock_state_s       pausable_clk_state_o
);
   logic         paused_q, paused_d;
   clock_state_s gated_q, gated_d;
   // Enter only while the next clock level is low, so a falling edge passes through
   // untouched; leave only on a rising edge so the copy restarts with a full high phase.
   always_comb begin
      paused_d = paused_q ? (pause_req_i || !unpausable_d_i.events.rising_edge)
                          : (pause_req_i && !unpausable_d_i.clk);
      gated_d  = (paused_q && paused_d) ? '0 : unpausable_d_i;
   end
   always_ff @(posedge sys_dom_i.clk) begin
      if (sys_dom_i.sync_rst) begin
         paused_q <= 1'b0;
         gated_q  <= '0;
      end else if (sys_dom_i.clk_en) begin
         paused_q <= !clear_state_i && paused_d;
         gated_q  <= clear_state_i ? '0 : gated_d;
      end
   end
   assign pause_ack_o          = paused_q;
   assign pausable_clk_state_o = gated_q;
endmodule

// File: rtl/clk_edge_generator.sv
// clk_edge_generator: rate counter and target comparator that toggles a generated clock,
// emitting unpausable and pausable clock states with edge events.
//   sys_dom_i              : clock / sync reset / cycle enable bundle
//   generation_en_i        : run enable, low freezes counter and clock
//   clear_state_i          : soft clear, same effect as reset
//   deltas_locked_in_i     : rate values valid (needed to start when START_ON_LOCK=1)
//   half_rate_target_i     : next toggle point from the rate tracker
//   recovered_events_i     : external edge events, used only with CLKS_ALOT_RESYNC_SNAP_EN
//   pause_req_i            : pause request for the pausable clock
//   pause_ack_o            : pausable clock parked low
//   counter_current_o      : free-running rate counter
//   unpausable_clk_state_o : generated clock plus events
//   pausable_clk_state_o   : gated copy of the unpausable state
// Define CLKS_ALOT_RESYNC_SNAP_EN to snap the clock phase to recovered edges.
module clk_edge_generator
   import clks_alot_p::*;
#(
   parameter int COUNTER_WIDTH = RATE_COUNTER_WIDTH,
   parameter bit START_ON_LOCK = 1'b1
) (
   input  common_p::clk_dom_s       sys_dom_i,
   input  logic                     generation_en_i,
   input  logic                     clear_state_i,
   input  logic                     deltas_locked_in_i,
   input  logic [COUNTER_WIDTH-1:0] half_rate_target_i,
   input  recovered_events_s        recovered_events_i,
   input  logic                     pause_req_i,
   output logic                     pause_ack_o,
   output logic [COUNTER_WIDTH-1:0] counter_current_o,
   output clock_state_s             unpausable_clk_state_o,
   output clock_state_s             pausable_clk_state_o
);
   gen_state_e               state_q, state_d;
   logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
   logic                     blank_q, blank_d;
   clock_state_s             unp_q, unp_d;
   logic                     kick, toggle, emit, snap, unused_rec;
   assign unused_rec = ^recovered_events_i;
`ifdef CLKS_ALOT_RESYNC_SNAP_EN
   // A recovered edge whose level disagrees with ours forces an immediate toggle.
   assign snap = state_q == GEN_RUN && generation_en_i && recovered_events_i.any_valid_edge
                 && (recovered_events_i.rising_edge != unp_q.clk);
`else
   assign snap = 1'b0;
`endif
   always_comb begin
      kick      = state_q == GEN_IDLE && generation_en_i && (deltas_locked_in_i || !START_ON_LOCK);
      // blank masks the comparator for the cycle the tracker needs to publish a new target
      toggle    = snap || (state_q == GEN_RUN && generation_en_i && !blank_q
                           && counter_q == half_rate_target_i);
      emit      = kick || toggle;
      state_d   = kick ? GEN_RUN : state_q;
      counter_d = (state_q == GEN_RUN && generation_en_i) ? counter_q + COUNTER_WIDTH'(1) : counter_q;
      blank_d   = generation_en_i ? emit : blank_q;
      unp_d.clk                   = kick || (toggle ? !unp_q.clk : unp_q.clk);
      unp_d.events.rising_edge    = emit && unp_d.clk;
      unp_d.events.falling_edge   = emit && !unp_d.clk;
      unp_d.events.any_valid_edge = emit;
   end
   always_ff @(posedge sys_dom_i.clk) begin
      if (sys_dom_i.sync_rst || (sys_dom_i.clk_en && clear_state_i)) begin
         state_q   <= GEN_IDLE;
         counter_q <= '0;
         blank_q   <= 1'b0;
         unp_q     <= '0;
      end else if (sys_dom_i.clk_en) begin
         state_q   <= state_d;
         counter_q <= counter_d;
         blank_q   <= blank_d;
         unp_q     <= unp_d;
      end
   end
   clk_pause_gate u_pause_gate (
      .sys_dom_i           (sys_dom_i),
      .clear_state_i       (clear_state_i),
      .pause_req_i         (pause_req_i),
      .unpausable_d_i      (unp_d),
      .pause_ack_o         (pause_ack_o),
      .pausable_clk_state_o(pausable_clk_state_o)
   );
   assign counter_current_o      = counter_q;
   assign unpausable_clk_state_o = unp_q;
endmodule

// File: tb/tb_clk_edge_generator.sv
// tb_clk_edge_generator: directed checks of kick, toggling, blanking, wrap, clk_en, pause and clear.
module tb_clk_edge_generator;
   import clks_alot_p::*;
   logic clk = 1'b0, rst = 1'b1, en = 1'b1, gen = 1'b0, lock = 1'b0, clear = 1'b0, req = 1'b0;
   logic [3:0] target = '0;
   recovered_events_s rec = '0;
   common_p::clk_dom_s dom;
   logic ack;
   logic [3:0] cnt, last;
   clock_state_s unp, pau;
   int checks = 0, errors = 0;
   int k, bad, edges, found;
   int exp_at [4] = '{3, 8, 11, 0};
   int wr_cnt [4] = '{15, 0, 1, 2};
   int wr_any [4] = '{0, 0, 0, 1};
   int ce_cnt [9] = '{3, 3, 4, 4, 5, 5, 6, 6, 7};
   int ce_fall[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
   assign dom = '{clk: clk, sync_rst: rst, clk_en: en};
   always #5 clk = ~clk;
   clk_edge_generator #(.COUNTER_WIDTH(4), .START_ON_LOCK(1'b1)) dut (
      .sys_dom_i             (dom),
      .generation_en_i       (gen),
      .clear_state_i         (clear),
      .deltas_locked_in_i    (lock),
      .half_rate_target_i    (target),
      .recovered_events_i    (rec),
      .pause_req_i           (req),
      .pause_ack_o           (ack),
      .counter_current_o     (cnt),
      .unpausable_clk_state_o(unp),
      .pausable_clk_state_o  (pau)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   initial begin
      step;
      step;
      rst = 1'b0;
      check("rst_clk", unp.clk, 0);
      check("rst_events", unp.events, 0);
      check("rst_cnt", cnt, 0);
      check("rst_ack", ack, 0);
      check("rst_pau", pau, 0);
      gen = 1'b1;
      step;
      check("nolock_clk", unp.clk, 0);
      check("nolock_cnt", cnt, 0);
      lock = 1'b1;
      target = 4'd3;
      step;
      check("kick_clk", unp.clk, 1);
      check("kick_rise", unp.events.rising_edge, 1);
      check("kick_any", unp.events.any_valid_edge, 1);
      check("kick_cnt", cnt, 0);
      check("kick_pau", pau.events.rising_edge, 1);
      k = 0;
      for (int c = 0; c < 40 && k < 4; c++) begin
         step;
         if (unp.events.any_valid_edge) begin
            last = cnt - 4'd1;
            check("toggle_at", last, exp_at[k]);
            check("toggle_lvl", unp.clk, (k % 2 == 1) ? 1 : 0);
            target = target + (unp.clk ? 4'd3 : 4'd5);
            step;
            check("pulse_one_cycle", unp.events.any_valid_edge, 0);
            k++;
         end
      end
      check("toggle_count", k, 4);
      target = 4'd2;
      step;
      check("pre_blank_fall", unp.events.falling_edge, 1);
      target = 4'd3;
      step;
      check("blank_ignore_evt", unp.events.any_valid_edge, 0);
      check("blank_ignore_clk", unp.clk, 0);
      target = 4'd13;
      clear = 1'b1;
      step;
      check("clr_cnt", cnt, 0);
      check("clr_clk", unp.clk, 0);
      check("clr_evt", unp.events, 0);
      clear = 1'b0;
      step;
      check("rekick_clk", unp.clk, 1);
      found = 0;
      for (int c = 0; c < 20 && found == 0; c++) begin
         step;
         if (unp.events.any_valid_edge) found = 1;
      end
      check("wrap_pre_found", found, 1);
      check("wrap_pre_cnt", cnt, 14);
      target = 4'd1;
      for (int i = 0; i < 4; i++) begin
         step;
         check("wrap_cnt", cnt, wr_cnt[i]);
         check("wrap_evt", unp.events.any_valid_edge, wr_any[i]);
      end
      check("wrap_clk", unp.clk, 1);
      target = 4'd5;
      for (int i = 0; i < 9; i++) begin
         en = (i % 2 == 0);
         step;
         check("ce_cnt", cnt, ce_cnt[i]);
         check("ce_fall", unp.events.falling_edge, ce_fall[i]);
      end
      en = 1'b1;
      target = 4'd9;
      step;
      step;
      step;
      check("pre_pause_rise", unp.events.rising_edge, 1);
      check("pre_pause_cnt", cnt, 10);
      target = 4'd13;
      step;
      req = 1'b1;
      step;
      check("pause_follow_clk", pau.clk, 1);
      check("pause_follow_ack", ack, 0);
      step;
      step;
      check("pause_fall_pass", pau.events.falling_edge, 1);
      check("pause_fall_clk", pau.clk, 0);
      check("pause_ack", ack, 1);
      target = target + 4'd5;
      bad = 0;
      edges = 0;
      for (int c = 0; c < 16; c++) begin
         step;
         if (unp.events.any_valid_edge) begin
            edges++;
            target = target + (unp.clk ? 4'd3 : 4'd5);
         end
         if (pau.clk || pau.events.any_valid_edge || !ack) bad++;
      end
      check("paused_held", bad, 0);
      check("paused_unp_edges", edges, 4);
      req = 1'b0;
      bad = 0;
      found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
         step;
         if (unp.events.rising_edge) begin
            found = 1;
            target = target + 4'd3;
            check("resume_clk", pau.clk, 1);
            check("resume_rise", pau.events.rising_edge, 1);
            check("resume_ack", ack, 0);
         end else if (pau.clk || !ack) bad++;
      end
      check("resume_found", found, 1);
      check("resume_wait_held", bad, 0);
`ifdef CLKS_ALOT_RESYNC_SNAP_EN
      rec = '{rising_edge: 1'b1, falling_edge: 1'b0, any_valid_edge: 1'b1};
      step;
      check("snap_same_clk", unp.clk, 1);
      check("snap_same_evt", unp.events.any_valid_edge, 0);
      rec = '0;
      step;
      step;
      check("snap_pre_fall", unp.events.falling_edge, 1);
      target = 4'd13;
      rec = '{rising_edge: 1'b1, falling_edge: 1'b0, any_valid_edge: 1'b1};
      step;
      check("snap_clk", unp.clk, 1);
      check("snap_rise", unp.events.rising_edge, 1);
      rec = '0;
`endif
      clear = 1'b1;
      step;
      check("clr2_cnt", cnt, 0);
      check("clr2_unp", unp, 0);
      check("clr2_pau", pau, 0);
      check("clr2_ack", ack, 0);
      clear = 1'b0;
      gen = 1'b0;
      req = 1'b1;
      step;
      check("idle_pause_ack", ack, 1);
      check("idle_pause_clk", pau.clk, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
